// File: rtl/pp_stream_gen.sv
// pp_stream_gen: streams AND-array partial-product bits, one per column per clock, to a column shift register.
// Optional PPGEN_BACK2BACK_EN lets a new operand pair load on the last step, so frames follow with no bubble.
module pp_stream_gen #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2*W-2:0] src_,
  output logic         busy,
  output logic         frame_valid
);
  localparam int SW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [SW-1:0] step;
  logic [W-1:0] a_q, b_q;
  logic last;
  assign last = step == SW'(W - 1);
  assign busy = state == RUN;
`ifdef PPGEN_BACK2BACK_EN
  assign in_ready = state == IDLE || (busy && last);
`else
  assign in_ready = state == IDLE;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= busy && last;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          step  <= '0;
          state <= RUN;
        end
        RUN: if (!last) step <= step + 1'b1;
`ifdef PPGEN_BACK2BACK_EN
        else if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          step <= '0;
        end
`endif
        else state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Column k idles for P leading steps so its first bit ends up in the MSB of an h(k)-deep register.
  for (genvar k = 0; k < 2*W-1; k++) begin : g_col
    localparam int H  = k < W ? k + 1 : 2*W - 1 - k;
    localparam int P  = W - H;
    localparam int I0 = k < W ? 0 : k - W + 1;
    logic [SW:0] d;
    logic [SW-1:0] ia, ib;
    assign d  = {1'b0, step} - (SW+1)'(P);
    assign ia = d[SW-1:0] + SW'(I0);
    assign ib = SW'(k) - ia;
    assign src_[k] = busy && !d[SW] && a_q[ia] && b_q[ib];
  end
endmodule

// File: tb/tb_pp_stream_gen.sv
// tb_pp_stream_gen: random and directed frames checked against column shift-register model sums.
module tb_pp_stream_gen;
  localparam int W = 21;
  localparam int N = 2*W - 1;
`ifdef PPGEN_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, busy, frame_valid;
  logic [N-1:0] src_;
  logic [W-1:0] colr [N] = '{default: '0};
  longint q [$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pp_stream_gen #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .src_(src_), .busy(busy), .frame_valid(frame_valid)
  );

  function automatic int hgt(int k);
    return k < W ? k + 1 : 2*W - 1 - k;
  endfunction

  function automatic longint model_sum();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'($countones(colr[k])) << k;
    return s;
  endfunction

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Downstream column registers: shift in at the LSB so the earliest bit ends at the MSB.
  always @(posedge clk)
    for (int k = 0; k < N; k++)
      colr[k] <= ((colr[k] << 1) | W'(src_[k])) & W'((64'(1) << hgt(k)) - 1);

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (frame_valid) begin
        chk("fv_pending", longint'(q.size() > 0), 1);
        if (q.size() > 0) chk("sum", model_sum(), q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(longint'(a) * longint'(b));
    end
  end

  task automatic send(logic [W-1:0] av, logic [W-1:0] bv);
    int n = 0;
    @(posedge clk) #1;
    in_valid = 1; a = av; b = bv;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk) #1;
    in_valid = 0; a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_fv();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_valid && n < 100);
    chk("fv_timeout", frame_valid, 1);
  endtask

  initial begin
    int last_fv, rdy_cnt;
    bit acc;
    rst_n = 0; in_valid = 1; a = 5; b = 5;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_src", src_, 0);
    chk("rst_fv", frame_valid, 0);
    in_valid = 0;
    @(posedge clk) #1 rst_n = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    send(1, 1);
    for (int t = 0; t < W; t++) begin
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("src_1x1", src_, t == W-1 ? 1 : 0);
      chk("run_ready", in_ready, (B2B && t == W-1) ? 1 : 0);
      chk("run_fv", frame_valid, 0);
    end
    @(negedge clk);
    chk("fv_1x1", frame_valid, 1);
    chk("done_ready", in_ready, 0);
    chk("model_1x1", model_sum(), 1);

    send({W{1'b1}}, {W{1'b1}});
    wait_fv();
    chk("col20", colr[20], 21'h1FFFFF);
    chk("col0", colr[0], 1);
    chk("col40", colr[40], 1);
    chk("sum_ones", model_sum(), ((64'(1) << W) - 1) * ((64'(1) << W) - 1));

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(W'($urandom), W'($urandom));
    end
    repeat (30) @(negedge clk);
    chk("rand_drained", q.size(), 0);

    send(7, 9);
    repeat (11) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_src", src_, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_fv", frame_valid, 0);
    @(negedge clk);
    @(posedge clk) #1 rst_n = 1;
    send(3, 5);
    wait_fv();
    chk("sum_3x5", model_sum(), 15);
    repeat (5) @(negedge clk);

    last_fv = -1; rdy_cnt = 0;
    @(posedge clk) #1;
    in_valid = 1; a = W'($urandom); b = W'($urandom);
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (frame_valid) begin
        if (last_fv >= 0) begin
          chk("b2b_period", cyc - last_fv, B2B ? W : W + 2);
          chk("b2b_ready_run", rdy_cnt, B2B ? 1 : 0);
        end
        last_fv = cyc; rdy_cnt = 0;
      end
      if (busy && in_ready) rdy_cnt++;
      acc = in_valid && in_ready;
      @(posedge clk) #1;
      if (acc) begin a = W'($urandom); b = W'($urandom); end
    end
    in_valid = 0;
    repeat (30) @(negedge clk);
    chk("final_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
